// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one valid/ready pipeline slot with flush and stall count.
// Optional skid slot (define PIPE_SKID_EN) registers in_ready.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   flush      squash stage contents (bubble) this cycle
//   in_valid   upstream payload valid
//   in_ready   stage can accept in_data this cycle
//   in_data    upstream payload (DATA_W)
//   out_valid  out_data holds a live instruction
//   out_ready  downstream accepts out_data this cycle
//   out_data   registered payload to next stage (DATA_W)
//   stall_cnt  saturating count of out_valid && !out_ready cycles (CNT_W)
module pipe_stage_reg #(
   parameter int unsigned          DATA_W    = 32,
   parameter logic [DATA_W-1:0]    RESET_VAL = '0,
   parameter int unsigned          CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic accept;
   logic xfer_out;

   assign accept   = in_valid && in_ready;
   assign xfer_out = out_valid && out_ready;

`ifdef PIPE_SKID_EN

   logic              skid_full;
   logic [DATA_W-1:0] skid_data;

   // Ready depends only on a flop, plus the flush gate.
   assign in_ready = !skid_full && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= RESET_VAL;
         skid_full <= 1'b0;
         skid_data <= RESET_VAL;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_data  <= RESET_VAL;
         skid_full <= 1'b0;
         skid_data <= RESET_VAL;
      end else if (skid_full) begin
         // Main slot is always valid while skid holds data.
         if (out_ready) begin
            out_data  <= skid_data;
            skid_full <= 1'b0;
         end
      end else if (accept) begin
         if (!out_valid || out_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
         end else begin
            skid_full <= 1'b1;
            skid_data <= in_data;
         end
      end else if (xfer_out) begin
         out_valid <= 1'b0;
      end
   end

`else

   assign in_ready = !flush && (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= RESET_VAL;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_data  <= RESET_VAL;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (xfer_out) begin
         // Data holds its last value; only the valid drops.
         out_valid <= 1'b0;
      end
   end

`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vectors, scoreboard queue, negedge monitor.
// Second instance with CNT_W=2 covers counter saturation.
module tb_pipe_stage_reg;

   localparam int unsigned DW = 8;
   localparam logic [DW-1:0] RV = 8'h5A;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [15:0]   stall_cnt;

   logic          in_ready2;
   logic          out_valid2;
   logic [DW-1:0] out_data2;
   logic [1:0]    stall_cnt2;

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .stall_cnt(stall_cnt2)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: a transfer happens at the next edge when valid && ready.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("mon_unexpected", {24'd0, out_data}, 32'hFFFF_FFFF);
         end else begin
            check("mon_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b0;
      step(1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'(RV));
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // 1: single accept, latency 1
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      exp_q.push_back(8'hA5);
      step(1);
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_data", 32'(out_data), 32'hA5);
      check("t1_in_ready", 32'(in_ready), 32'd1);

      // 2: back-to-back stream, no bubbles
      for (int i = 1; i <= 3; i++) begin
         in_data = DW'(i);
         exp_q.push_back(DW'(i));
         step(1);
         check("t2_out_valid", 32'(out_valid), 32'd1);
         check("t2_out_data", 32'(out_data), i);
      end
      in_valid = 1'b0;
      step(1);
      check("drain_out_valid", 32'(out_valid), 32'd0);
      check("drain_hold_data", 32'(out_data), 32'h3);

      // 3: stall with 0x7
      in_valid = 1'b1; in_data = 8'h07;
      exp_q.push_back(8'h07);
      step(1);
      in_valid = 1'b0; out_ready = 1'b0;
      step(4);
      check("t3_hold_data", 32'(out_data), 32'h07);
      check("t3_stall_cnt", 32'(stall_cnt), 32'd4);
`ifdef PIPE_SKID_EN
      check("t3_in_ready", 32'(in_ready), 32'd1);
`else
      check("t3_in_ready", 32'(in_ready), 32'd0);
`endif
      // 5: saturation on the CNT_W=2 instance
      step(2);
      check("t5_stall_cnt", 32'(stall_cnt), 32'd6);
      check("t5_sat_cnt", 32'(stall_cnt2), 32'd3);

      // 4: flush; 0x7 still leaves downstream, 0x9 refused
      flush = 1'b1; in_valid = 1'b1; in_data = 8'h09; out_ready = 1'b1;
      #1;
      check("t4_in_ready", 32'(in_ready), 32'd0);
      step(1);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check("t4_out_valid", 32'(out_valid), 32'd0);
      check("t4_out_data", 32'(out_data), 32'(RV));
      check("t4_cnt_kept", 32'(stall_cnt), 32'd6);
      check("t4_in_ready_after", 32'(in_ready), 32'd1);

      // 6: two sends against back-pressure
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0B;
      exp_q.push_back(8'h0B);
      step(1);
      in_data = 8'h0C;
`ifdef PIPE_SKID_EN
      exp_q.push_back(8'h0C);
      step(1);
      in_valid = 1'b0;
      check("t6_in_ready_full", 32'(in_ready), 32'd0);
      check("t6_main_data", 32'(out_data), 32'h0B);
      out_ready = 1'b1;
      step(1);
      check("t6_in_ready_free", 32'(in_ready), 32'd1);
      check("t6_skid_data", 32'(out_data), 32'h0C);
      step(1);
`else
      check("t6_in_ready_full", 32'(in_ready), 32'd0);
      step(1);
      in_valid = 1'b0;
      check("t6_main_data", 32'(out_data), 32'h0B);
      out_ready = 1'b1;
      step(1);
      check("t6_in_ready_free", 32'(in_ready), 32'd1);
`endif
      check("t6_empty", 32'(out_valid), 32'd0);

      // Reset mid-transfer discards the payload
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0E;
      step(1);
      in_valid = 1'b0;
      check("mid_loaded", 32'(out_data), 32'h0E);
      rst = 1'b0;
      #2;
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_out_data", 32'(out_data), 32'(RV));
      check("mid_stall_cnt", 32'(stall_cnt), 32'd0);
      step(1);
      rst = 1'b1;
      #1;
      check("mid_in_ready", 32'(in_ready), 32'd1);
      step(2);

      check("sb_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
